// File: rtl/psum_out_buffer.sv
// psum_out_buffer: output buffer of the PE datapath.
// Circular FIFO with first-word-fall-through read side and valid/ready
// handshake. Tracks popped words per output row and flags the last psum
// of each row on out_last. Overflowing pushes are dropped and a sticky
// flag records them.
// Optional feature: define OUTBUF_LEVEL_EN to expose the occupancy on
// outbuf_level; without it the port is absent and behaviour is unchanged.
module psum_out_buffer #(
  parameter int DATA_WIDTH = 17,
  parameter int DEPTH      = 8,
  parameter int ADDR_LEN   = 3,
  parameter int ROW_LEN_W  = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  outbuf_write,
  input  logic [DATA_WIDTH-1:0] outbuf_inp,
  output logic                  outbuf_full,
  input  logic [ROW_LEN_W-1:0]  row_len,
  input  logic                  row_len_ld,
  input  logic                  out_ready,
  output logic                  out_valid,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_last,
  output logic                  outbuf_overflow
`ifdef OUTBUF_LEVEL_EN
  ,
  output logic [ADDR_LEN:0]     outbuf_level
`endif
);

  localparam logic [ADDR_LEN:0]  DEPTH_C = (ADDR_LEN+1)'(DEPTH);
  localparam logic [ROW_LEN_W-1:0] ONE_C = ROW_LEN_W'(1);

  // Storage; read asynchronously so the head word falls through.
  logic [DATA_WIDTH-1:0] mem [DEPTH];

  // Pointers carry one extra wrap bit to distinguish full from empty.
  logic [ADDR_LEN:0]     wptr_reg;
  logic [ADDR_LEN:0]     rptr_reg;
  logic [ADDR_LEN:0]     count;
  logic [ROW_LEN_W-1:0]  row_len_reg;
  logic [ROW_LEN_W-1:0]  row_cnt_reg;
  logic                  overflow_reg;
  logic                  pop;
  logic                  push_ok;

  // Status flags derived only from registered pointers.
  always_comb begin
    count       = wptr_reg - rptr_reg;
    outbuf_full = (count == DEPTH_C);
    out_valid   = (count != '0);
    out_data    = out_valid ? mem[rptr_reg[ADDR_LEN-1:0]] : '0;
    out_last    = out_valid & (row_cnt_reg == (row_len_reg - ONE_C));
    pop         = out_ready & out_valid;
    // A pop in the same cycle frees a slot, so a full FIFO may still accept.
    push_ok     = outbuf_write & (~outbuf_full | pop);
  end

  assign outbuf_overflow = overflow_reg;

`ifdef OUTBUF_LEVEL_EN
  assign outbuf_level = count;
`endif

  // Memory write port; contents need no reset because pointers gate reads.
  always_ff @(posedge clk) begin
    if (!rst && push_ok) begin
      mem[wptr_reg[ADDR_LEN-1:0]] <= outbuf_inp;
    end
  end

  // Pointer update and sticky overflow flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      wptr_reg     <= '0;
      rptr_reg     <= '0;
      overflow_reg <= 1'b0;
    end else begin
      if (push_ok) begin
        wptr_reg <= wptr_reg + 1'b1;
      end
      if (pop) begin
        rptr_reg <= rptr_reg + 1'b1;
      end
      if (outbuf_write && !push_ok) begin
        overflow_reg <= 1'b1;
      end
    end
  end

  // Row tracking: a zero row length is treated as one; a load restarts the row.
  always_ff @(posedge clk) begin
    if (rst) begin
      row_len_reg <= ONE_C;
      row_cnt_reg <= '0;
    end else if (row_len_ld) begin
      row_len_reg <= (row_len == '0) ? ONE_C : row_len;
      row_cnt_reg <= '0;
    end else if (pop) begin
      row_cnt_reg <= out_last ? '0 : row_cnt_reg + ONE_C;
    end
  end

endmodule

// File: tb/tb_psum_out_buffer.sv
// Testbench for psum_out_buffer: table-driven vectors, directed corner
// sequences and randomized traffic, all checked against a queue-based model.
module tb_psum_out_buffer;

  localparam int DW = 17;

  logic          clk = 1'b0;
  logic          rst;
  logic          outbuf_write;
  logic [DW-1:0] outbuf_inp;
  logic          outbuf_full;
  logic [7:0]    row_len;
  logic          row_len_ld;
  logic          out_ready;
  logic          out_valid;
  logic [DW-1:0] out_data;
  logic          out_last;
  logic          outbuf_overflow;
`ifdef OUTBUF_LEVEL_EN
  logic [3:0]    outbuf_level;
`endif

  always #5 clk = ~clk;

  psum_out_buffer dut (
    .clk             (clk),
    .rst             (rst),
    .outbuf_write    (outbuf_write),
    .outbuf_inp      (outbuf_inp),
    .outbuf_full     (outbuf_full),
    .row_len         (row_len),
    .row_len_ld      (row_len_ld),
    .out_ready       (out_ready),
    .out_valid       (out_valid),
    .out_data        (out_data),
    .out_last        (out_last),
    .outbuf_overflow (outbuf_overflow)
`ifdef OUTBUF_LEVEL_EN
    ,
    .outbuf_level    (outbuf_level)
`endif
  );

  int n_cmp  = 0;
  int n_fail = 0;

  // Behavioural model: a queue of words plus row position and length.
  int m_q[$];
  int m_rlen = 1;
  int m_rcnt = 0;
  int m_ovf  = 0;

  function automatic int m_valid(); return (m_q.size() != 0) ? 1 : 0; endfunction
  function automatic int m_data();  return (m_q.size() != 0) ? m_q[0] : 0; endfunction
  function automatic int m_full();  return (m_q.size() == 8) ? 1 : 0; endfunction
  function automatic int m_last();
    return (m_q.size() != 0 && m_rcnt == m_rlen - 1) ? 1 : 0;
  endfunction

  function automatic void chk(string nm, int act, int exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endfunction

  // Advance the model by one clock using the currently driven inputs.
  function automatic void model_edge();
    int was_last;
    int pop;
    int room;
    if (rst) begin
      m_q.delete();
      m_rlen = 1;
      m_rcnt = 0;
      m_ovf  = 0;
      return;
    end
    was_last = m_last();
    pop  = (out_ready && m_q.size() != 0) ? 1 : 0;
    room = (m_q.size() < 8 || pop) ? 1 : 0;
    if (pop) void'(m_q.pop_front());
    if (outbuf_write) begin
      if (room) m_q.push_back(int'(outbuf_inp));
      else      m_ovf = 1;
    end
    if (row_len_ld) begin
      m_rlen = (row_len == 0) ? 1 : int'(row_len);
      m_rcnt = 0;
    end else if (pop) begin
      m_rcnt = was_last ? 0 : m_rcnt + 1;
    end
  endfunction

  function automatic void check_model(string tag);
    chk({tag, ".valid"}, int'(out_valid), m_valid());
    chk({tag, ".data"},  int'(out_data),  m_data());
    chk({tag, ".full"},  int'(outbuf_full), m_full());
    chk({tag, ".last"},  int'(out_last),  m_last());
    chk({tag, ".ovf"},   int'(outbuf_overflow), m_ovf);
`ifdef OUTBUF_LEVEL_EN
    chk({tag, ".level"}, int'(outbuf_level), m_q.size());
`endif
  endfunction

  // One clock: model follows the same edge, outputs sampled 1 time unit later.
  task automatic tick(string tag);
    model_edge();
    @(posedge clk);
    #1;
    check_model(tag);
  endtask

  task automatic drive(input logic w, input int d, input logic rdy,
                       input logic ld, input int rl);
    outbuf_write = w;
    outbuf_inp   = DW'(d);
    out_ready    = rdy;
    row_len_ld   = ld;
    row_len      = 8'(rl);
  endtask

  task automatic do_reset();
    drive(0, 0, 0, 0, 0);
    rst = 1'b1;
    tick("rst");
    rst = 1'b0;
  endtask

  typedef struct {
    logic w; int d; logic rdy; logic ld; int rl;
    logic e_valid; int e_data; logic e_full; logic e_last;
  } vec_t;

  vec_t vt[$];

  initial begin
    vec_t v;
    rst = 1'b0;
    drive(0, 0, 0, 0, 0);
    @(posedge clk);
    #1;
    do_reset();
    chk("reset.valid", int'(out_valid), 0);
    chk("reset.full",  int'(outbuf_full), 0);
    chk("reset.last",  int'(out_last), 0);
    chk("reset.data",  int'(out_data), 0);
    chk("reset.ovf",   int'(outbuf_overflow), 0);

    // Expected values below are the outputs seen after the edge.
    //        w  d        rdy ld rl  valid data     full last
    vt.push_back('{1, 'h00011, 0, 0, 0, 1, 'h00011, 0, 1});
    vt.push_back('{0, 0,       1, 0, 0, 0, 0,       0, 0});
    vt.push_back('{0, 0,       0, 1, 3, 0, 0,       0, 0});
    vt.push_back('{1, 'h0000A, 0, 0, 0, 1, 'h0000A, 0, 0});
    vt.push_back('{1, 'h0000B, 0, 0, 0, 1, 'h0000A, 0, 0});
    vt.push_back('{1, 'h0000C, 0, 0, 0, 1, 'h0000A, 0, 0});
    vt.push_back('{0, 0,       1, 0, 0, 1, 'h0000B, 0, 0});
    vt.push_back('{0, 0,       1, 0, 0, 1, 'h0000C, 0, 1});
    vt.push_back('{1, 'h1ABCD, 1, 0, 0, 1, 'h1ABCD, 0, 0});
    vt.push_back('{0, 0,       1, 0, 0, 0, 0,       0, 0});
    vt.push_back('{0, 0,       1, 0, 0, 0, 0,       0, 0});
    for (int i = 0; i < vt.size(); i++) begin
      v = vt[i];
      drive(v.w, v.d, v.rdy, v.ld, v.rl);
      tick($sformatf("vec%0d", i));
      chk($sformatf("vec%0d.valid", i), int'(out_valid), int'(v.e_valid));
      chk($sformatf("vec%0d.data", i),  int'(out_data),  v.e_data);
      chk($sformatf("vec%0d.full", i),  int'(outbuf_full), int'(v.e_full));
      chk($sformatf("vec%0d.last", i),  int'(out_last),  int'(v.e_last));
      $display("vec %0d: w=%0d d=%05h rdy=%0d ld=%0d -> valid=%0d data=%05h full=%0d last=%0d",
               i, v.w, v.d, v.rdy, v.ld, out_valid, out_data, outbuf_full, out_last);
    end

    // Fill, drop a ninth word, drain in order.
    do_reset();
    for (int i = 1; i <= 8; i++) begin
      drive(1, i, 0, 0, 0);
      tick("fill");
    end
    chk("fill.full", int'(outbuf_full), 1);
    drive(1, 'h1FFFF, 0, 0, 0);
    tick("drop");
    chk("drop.ovf", int'(outbuf_overflow), 1);
    $display("seq overflow: full=%0d ovf=%0d", outbuf_full, outbuf_overflow);
    for (int i = 1; i <= 8; i++) begin
      chk("drain.data", int'(out_data), i);
      drive(0, 0, 1, 0, 0);
      tick("drain");
    end
    chk("drain.empty", int'(out_valid), 0);

    // Full FIFO with simultaneous push and pop.
    do_reset();
    for (int i = 1; i <= 8; i++) begin
      drive(1, i, 0, 0, 0);
      tick("fill2");
    end
    drive(1, 9, 1, 0, 0);
    tick("pushpop");
    chk("pushpop.full", int'(outbuf_full), 1);
    chk("pushpop.ovf",  int'(outbuf_overflow), 0);
    $display("seq push+pop on full: full=%0d ovf=%0d head=%0h", outbuf_full, outbuf_overflow, out_data);
    for (int i = 2; i <= 9; i++) begin
      chk("drain2.data", int'(out_data), i);
      drive(0, 0, 1, 0, 0);
      tick("drain2");
    end

    // Row length 0 behaves as 1: every word is last.
    drive(0, 0, 0, 1, 0);
    tick("ld0");
    for (int i = 0; i < 3; i++) begin
      drive(1, 'h100 + i, 0, 0, 0);
      tick("row0push");
    end
    for (int i = 0; i < 3; i++) begin
      chk("row0.last", int'(out_last), 1);
      drive(0, 0, 1, 0, 0);
      tick("row0pop");
    end
    $display("seq row_len=0 done");

    // Reset mid-row with contents: everything discarded, row count restarts.
    drive(0, 0, 0, 1, 4);
    tick("ld4");
    for (int i = 0; i < 5; i++) begin
      drive(1, 'h200 + i, (i >= 3), 0, 0);
      tick("midpush");
    end
    do_reset();
    chk("midrst.valid", int'(out_valid), 0);
    chk("midrst.full",  int'(outbuf_full), 0);
    chk("midrst.ovf",   int'(outbuf_overflow), 0);
    drive(1, 'h333, 0, 0, 0);
    tick("postrst");
    chk("postrst.last", int'(out_last), 1);
    $display("seq mid-stream reset: valid=%0d last=%0d", out_valid, out_last);

    // Randomized traffic across many pointer wraps.
    do_reset();
    for (int i = 0; i < 400; i++) begin
      drive(($urandom_range(0, 99) < 60), int'($urandom_range(0, 'h1FFFF)),
            ($urandom_range(0, 99) < 50), ($urandom_range(0, 99) < 4),
            int'($urandom_range(0, 5)));
      tick($sformatf("rnd%0d", i));
    end
    $display("random traffic: 400 cycles");

    drive(0, 0, 0, 0, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
